// File: rtl/mem_stage_access_unit_pkg.sv
// rtl/mem_stage_access_unit_pkg.sv - shared size codes, FSM states and byte-enable constants
package mem_stage_access_unit_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    // Big-endian lane masks for the lowest address of each access size.
    localparam logic [3:0] BE_BYTE = 4'b1000;
    localparam logic [3:0] BE_HALF = 4'b1100;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Halves need an even address; words (and the reserved code) need 4-byte alignment.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lo);
        logic ok;
        case (size)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = ~lo[0];
            default: ok = (lo == 2'b00);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_stage_access_unit_lane_align.sv
// rtl/mem_stage_access_unit_lane_align.sv - big-endian lane steering for stores and load extension
module mem_lane_align
    import mem_stage_access_unit_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        se_i,
    input  logic [31:0] st_data_i,
    input  logic [31:0] ld_word_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ld_data_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Pick the addressed lane (byte 0 sits in bits 31:24) and build enables, store data, load data.
    always_comb begin
        ld_byte = ld_word_i[31:24];
        case (addr_lo_i)
            2'd0: ld_byte = ld_word_i[31:24];
            2'd1: ld_byte = ld_word_i[23:16];
            2'd2: ld_byte = ld_word_i[15:8];
            default: ld_byte = ld_word_i[7:0];
        endcase
        ld_half = addr_lo_i[1] ? ld_word_i[15:0] : ld_word_i[31:16];

        be_o      = BE_WORD;
        wdata_o   = st_data_i;
        ld_data_o = ld_word_i;
        case (size_i)
            SZ_BYTE: begin
                be_o      = BE_BYTE >> addr_lo_i;
                wdata_o   = {4{st_data_i[7:0]}};
                ld_data_o = {{24{se_i & ld_byte[7]}}, ld_byte};
            end
            SZ_HALF: begin
                be_o      = BE_HALF >> {addr_lo_i[1], 1'b0};
                wdata_o   = {2{st_data_i[15:0]}};
                ld_data_o = {{16{se_i & ld_half[15]}}, ld_half};
            end
            default: begin
                be_o      = BE_WORD;
                wdata_o   = st_data_i;
                ld_data_o = ld_word_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage_access_unit.sv
// rtl/mem_stage_access_unit.sv - MEM-stage req/ack data-memory access FSM with stall and write-back
module mem_stage_access_unit
    import mem_stage_access_unit_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        R,
    input  logic        E_mem,
    input  logic        rw_dm_mem,
    input  logic [1:0]  size_mem,
    input  logic        se_mem,
    input  logic        load_mem,
    input  logic        rf_le_mem,
    input  logic [31:0] alu_out_mem,
    input  logic [31:0] df_a_mem,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ack,
    output logic        stall_mem,
    output logic [31:0] wb_data,
    output logic        wb_le,
    output logic        misalign,
    output logic        bus_err
);

    // Counter value seen in the last permitted BUSY cycle; unused when TIMEOUT is 0.
    localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [31:0]        rbuf_q;
    logic               err_q;
    logic               req_q;
    logic               we_q;
    logic [3:0]         be_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic [1:0]         size_q;
    logic               se_q;
    logic [1:0]         lo_q;

    logic               idle;
    logic               live_aligned;
    logic               start;
    logic               timeout_hit;

    logic [1:0]         al_size;
    logic [1:0]         al_lo;
    logic               al_se;
    logic [3:0]         al_be;
    logic [31:0]        al_wdata;
    logic [31:0]        al_ld;

    assign idle         = (state_q == ST_IDLE);
    assign live_aligned = is_aligned(size_mem, alu_out_mem[1:0]);
    assign start        = idle & E_mem & live_aligned;
    assign cnt_d        = cnt_q + 1'b1;
    assign timeout_hit  = (TIMEOUT != 0) && (cnt_q == TO_LAST);

    // In IDLE the aligner sees the live instruction (store side); afterwards the latched one (load side).
    assign al_size = idle ? size_mem         : size_q;
    assign al_lo   = idle ? alu_out_mem[1:0] : lo_q;
    assign al_se   = idle ? se_mem           : se_q;

    mem_lane_align u_lane_align (
        .size_i    (al_size),
        .addr_lo_i (al_lo),
        .se_i      (al_se),
        .st_data_i (df_a_mem),
        .ld_word_i (rbuf_q),
        .be_o      (al_be),
        .wdata_o   (al_wdata),
        .ld_data_o (al_ld)
    );

    // Transaction FSM: latch on start, wait for ack or timeout, retire for one cycle.
    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rbuf_q  <= '0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= SZ_BYTE;
            se_q    <= 1'b0;
            lo_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_BUSY;
                        req_q   <= 1'b1;
                        we_q    <= rw_dm_mem;
                        be_q    <= al_be;
                        addr_q  <= {alu_out_mem[31:2], 2'b00};
                        wdata_q <= al_wdata;
                        size_q  <= size_mem;
                        se_q    <= se_mem;
                        lo_q    <= alu_out_mem[1:0];
                        cnt_q   <= '0;
                        err_q   <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    if (dm_ack) begin
                        rbuf_q  <= dm_rdata;
                        req_q   <= 1'b0;
                        state_q <= ST_DONE;
                    end else if (timeout_hit) begin
                        rbuf_q  <= '0;
                        req_q   <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q   <= cnt_d;
                    end
                end
                ST_DONE: begin
                    err_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    req_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign dm_req    = req_q;
    assign dm_we     = req_q & we_q;
    assign dm_addr   = addr_q;
    assign dm_be     = be_q;
    assign dm_wdata  = wdata_q;
    assign bus_err   = err_q;

    // Stall and misalign are decided from the live instruction in IDLE; reset forces them low.
    assign stall_mem = R & (start | (state_q == ST_BUSY));
    assign misalign  = R & idle & E_mem & ~live_aligned;

    // Write-back: pass the ALU result for non-memory ops, extended load data when retiring a load.
    always_comb begin
        wb_data = alu_out_mem;
        wb_le   = 1'b0;
        case (state_q)
            ST_IDLE: wb_le = R & ~E_mem & rf_le_mem;
            ST_DONE: begin
                if (load_mem) wb_data = al_ld;
                wb_le = R & rf_le_mem & ~err_q;
            end
            default: wb_le = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_mem_stage_access_unit.sv
// tb/tb_mem_stage_access_unit.sv - randomized self-checking bench with behavioural reference model
module tb_mem_stage_access_unit;

    localparam int TIMEOUT = 16;
    localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10;

    logic        clk = 1'b0;
    logic        R = 1'b0;
    logic        E_mem = 1'b0, rw_dm_mem = 1'b0, se_mem = 1'b0, load_mem = 1'b0, rf_le_mem = 1'b0;
    logic [1:0]  size_mem = 2'b00;
    logic [31:0] alu_out_mem = '0, df_a_mem = '0;
    logic        dm_ack = 1'b0;
    logic [31:0] dm_rdata = '0;
    logic        dm_req, dm_we, stall_mem, wb_le, misalign, bus_err;
    logic [31:0] dm_addr, dm_wdata, wb_data;
    logic [3:0]  dm_be;

    mem_stage_access_unit #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk(clk), .R(R), .E_mem(E_mem), .rw_dm_mem(rw_dm_mem), .size_mem(size_mem),
        .se_mem(se_mem), .load_mem(load_mem), .rf_le_mem(rf_le_mem),
        .alu_out_mem(alu_out_mem), .df_a_mem(df_a_mem),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack), .stall_mem(stall_mem),
        .wb_data(wb_data), .wb_le(wb_le), .misalign(misalign), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference rules ----------------
    function automatic int nb(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : ((sz == 2'b01) ? 2 : 4);
    endfunction
    function automatic bit aligned_ok(input logic [1:0] sz, input logic [31:0] a);
        return (int'(a[1:0]) % nb(sz)) == 0;
    endfunction
    function automatic int lane_base(input logic [1:0] sz, input logic [31:0] a);
        return (int'(a[1:0]) / nb(sz)) * nb(sz);
    endfunction
    function automatic logic [3:0] be_of(input logic [1:0] sz, input logic [31:0] a);
        logic [3:0] r = 4'b0000;
        for (int i = 0; i < nb(sz); i++) r[3 - (lane_base(sz, a) + i)] = 1'b1;
        return r;
    endfunction
    function automatic logic [31:0] wdata_of(input logic [1:0] sz, input logic [31:0] d);
        if (nb(sz) == 1) return {24'd0, d[7:0]} * 32'h01010101;
        if (nb(sz) == 2) return {16'd0, d[15:0]} * 32'h00010001;
        return d;
    endfunction
    function automatic logic [31:0] load_of(input logic [1:0] sz, input logic se,
                                            input logic [31:0] a, input logic [31:0] rd);
        int n = nb(sz);
        logic [31:0] mask, v;
        if (n == 4) return rd;
        mask = (32'd1 << (8 * n)) - 32'd1;
        v = (rd >> (8 * (4 - lane_base(sz, a) - n))) & mask;
        if (se && v[8 * n - 1]) v = v | ~mask;
        return v;
    endfunction

    // ---------------- memory responder ----------------
    int          ack_at = 1;
    logic [31:0] rdata_val = '0;
    int          busy_cnt = 0;
    int          acks_taken = 0;

    always @(posedge clk) begin
        #1;
        if (!R) begin
            dm_ack = 1'b0;
            busy_cnt = 0;
        end else if (dm_req) begin
            busy_cnt++;
            dm_ack = (ack_at != 0) && (busy_cnt == ack_at);
            if (dm_ack) begin
                dm_rdata = rdata_val;
                acks_taken++;
            end else begin
                dm_rdata = $urandom;
            end
        end else begin
            busy_cnt = 0;
            dm_ack = ($urandom_range(0, 3) == 0);
            dm_rdata = $urandom;
        end
    end

    // ---------------- model + compare ----------------
    int          m_phase = 0;          // 0 waiting for an instruction, 1 bus cycle open, 2 retiring
    int          m_wait = 0;
    logic        m_err = 1'b0;
    logic [31:0] m_buf = '0;
    logic        m_we = 1'b0, m_se = 1'b0;
    logic [1:0]  m_sz = 2'b00;
    logic [31:0] m_a = '0, m_d = '0;

    int          rec_stall = 0, rec_req = 0, rec_mis = 0, rec_berr = 0, rec_rise = 0;
    logic        prev_req = 1'b0;
    logic [3:0]  rec_be = '0;
    logic [31:0] rec_addr = '0, rec_wdata = '0, rec_wb_data = '0;
    logic        rec_wb_le = 1'b0;

    always @(negedge clk) begin
        logic e_stall, e_req, e_mis, e_berr, e_le, chk_wb;
        logic [31:0] e_wb;
        if (!R) begin
            check("rst_dm_req", dm_req, 0);
            check("rst_dm_we", dm_we, 0);
            check("rst_dm_be", dm_be, 0);
            check("rst_stall", stall_mem, 0);
            check("rst_misalign", misalign, 0);
            check("rst_bus_err", bus_err, 0);
            check("rst_wb_le", wb_le, 0);
            m_phase = 0;
            m_err = 1'b0;
            prev_req = 1'b0;
        end else begin
            e_stall = 0; e_req = 0; e_mis = 0; e_berr = 0; e_le = 0; chk_wb = 0; e_wb = alu_out_mem;
            if (m_phase == 0) begin
                if (E_mem) begin
                    e_stall = aligned_ok(size_mem, alu_out_mem);
                    e_mis = !aligned_ok(size_mem, alu_out_mem);
                end else begin
                    e_le = rf_le_mem;
                    chk_wb = 1;
                end
            end else if (m_phase == 1) begin
                e_req = 1;
                e_stall = 1;
                check("dm_we", dm_we, m_we);
                check("dm_be", dm_be, be_of(m_sz, m_a));
                check("dm_addr", dm_addr, m_a & 32'hFFFF_FFFC);
                if (m_we) check("dm_wdata", dm_wdata, wdata_of(m_sz, m_d));
            end else begin
                e_berr = m_err;
                e_le = rf_le_mem & !m_err;
                e_wb = load_mem ? load_of(m_sz, m_se, m_a, m_buf) : alu_out_mem;
                chk_wb = 1;
            end
            check("dm_req", dm_req, e_req);
            check("stall_mem", stall_mem, e_stall);
            check("misalign", misalign, e_mis);
            check("bus_err", bus_err, e_berr);
            check("wb_le", wb_le, e_le);
            if (chk_wb) check("wb_data", wb_data, e_wb);

            rec_stall += stall_mem;
            rec_req += dm_req;
            rec_mis += misalign;
            rec_berr += bus_err;
            if (dm_req && !prev_req) rec_rise++;
            prev_req = dm_req;
            if (dm_req) begin
                rec_be = dm_be; rec_addr = dm_addr; rec_wdata = dm_wdata;
            end
            if (!stall_mem) begin
                rec_wb_data = wb_data; rec_wb_le = wb_le;
            end

            if (m_phase == 0) begin
                if (E_mem && aligned_ok(size_mem, alu_out_mem)) begin
                    m_phase = 1; m_wait = 0; m_err = 0;
                    m_we = rw_dm_mem; m_sz = size_mem; m_se = se_mem; m_a = alu_out_mem; m_d = df_a_mem;
                end
            end else if (m_phase == 1) begin
                m_wait++;
                if (dm_ack) begin
                    m_buf = dm_rdata; m_phase = 2;
                end else if (TIMEOUT != 0 && m_wait == TIMEOUT) begin
                    m_buf = 0; m_err = 1; m_phase = 2;
                end
            end else begin
                m_phase = 0; m_err = 0;
            end
        end
    end

    // ---------------- driver ----------------
    int st_stall, st_req, st_mis, st_berr;

    task automatic issue(input logic e, input logic rw, input logic [1:0] sz, input logic se,
                         input logic ld, input logic rfle, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] rd, input int ack);
        int n = 0;
        st_stall = rec_stall; st_req = rec_req; st_mis = rec_mis; st_berr = rec_berr;
        ack_at = ack; rdata_val = rd;
        E_mem = e; rw_dm_mem = rw; size_mem = sz; se_mem = se; load_mem = ld;
        rf_le_mem = rfle; alu_out_mem = a; df_a_mem = d;
        forever begin
            @(negedge clk);
            if (!stall_mem) break;
            n++;
            if (n > 64) begin
                tests_run++; failed++;
                $display("FAIL retire_bound actual=%0d cycles required=<=64", n);
                break;
            end
        end
        @(posedge clk); #1;
        E_mem = 0; rw_dm_mem = 0; load_mem = 0; rf_le_mem = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, r0, n;
        logic [31:0] a;
        logic [1:0] sz;
        logic rw, e;
        int r, ack;

        repeat (3) @(posedge clk);
        #1; R = 1;
        @(posedge clk); #1;

        // word store, ack in second bus cycle
        issue(1, 1, W, 0, 0, 0, 32'h100, 32'hDEADBEEF, 0, 2);
        check("t1_be", rec_be, 4'b1111);
        check("t1_wdata", rec_wdata, 32'hDEADBEEF);
        check("t1_stall_cycles", rec_stall - st_stall, 3);
        check("t1_wb_le", rec_wb_le, 0);

        // byte loads, signed and unsigned
        issue(1, 0, B, 1, 1, 1, 32'h203, 0, 32'h112233F0, 1);
        check("t2_be", rec_be, 4'b0001);
        check("t2_wb_se", rec_wb_data, 32'hFFFFFFF0);
        check("t2_wb_le", rec_wb_le, 1);
        issue(1, 0, B, 0, 1, 1, 32'h203, 0, 32'h112233F0, 3);
        check("t2_wb_ze", rec_wb_data, 32'h000000F0);

        // half store
        issue(1, 1, H, 0, 0, 0, 32'h302, 32'h0000ABCD, 0, 1);
        check("t3_be", rec_be, 4'b0011);
        check("t3_wdata", rec_wdata, 32'hABCDABCD);
        check("t3_addr", rec_addr, 32'h300);

        // misaligned word load
        issue(1, 0, W, 0, 1, 1, 32'h102, 0, 0, 1);
        check("t4_misalign", rec_mis - st_mis, 1);
        check("t4_req_cycles", rec_req - st_req, 0);
        check("t4_stall_cycles", rec_stall - st_stall, 0);
        check("t4_wb_le", rec_wb_le, 0);

        // no ack: timeout
        issue(1, 0, W, 0, 1, 1, 32'h600, 0, 0, 0);
        check("t5_req_cycles", rec_req - st_req, 16);
        check("t5_bus_err", rec_berr - st_berr, 1);
        check("t5_wb_le", rec_wb_le, 0);
        check("t5_wb_data", rec_wb_data, 0);

        // ack in the last permitted cycle wins
        issue(1, 0, W, 0, 1, 1, 32'h604, 0, 32'h89ABCDEF, 16);
        check("t5b_req_cycles", rec_req - st_req, 16);
        check("t5b_bus_err", rec_berr - st_berr, 0);
        check("t5b_wb_data", rec_wb_data, 32'h89ABCDEF);

        // reset while a bus cycle is open
        ack_at = 0;
        E_mem = 1; rw_dm_mem = 0; size_mem = W; se_mem = 0; load_mem = 1; rf_le_mem = 1;
        alu_out_mem = 32'h400;
        n = 0;
        while (!dm_req && n < 10) begin @(negedge clk); n++; end
        check("t6_req_open", dm_req, 1);
        @(posedge clk); #3;
        R = 0;
        #1;
        check("t6_req_async", dm_req, 0);
        check("t6_stall_async", stall_mem, 0);
        @(posedge clk); #1;
        E_mem = 0; load_mem = 0; rf_le_mem = 0;
        @(posedge clk); #1;
        R = 1;
        a0 = acks_taken; r0 = rec_rise;
        issue(1, 0, W, 0, 1, 1, 32'h500, 0, 32'hCAFEF00D, 1);
        check("t6_load_data", rec_wb_data, 32'hCAFEF00D);
        issue(1, 1, W, 0, 0, 0, 32'h504, 32'h13572468, 0, 2);
        check("t6_acks", acks_taken - a0, 2);
        check("t6_bus_cycles", rec_rise - r0, 2);

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            e = ($urandom_range(0, 3) != 0);
            rw = $urandom_range(0, 1);
            sz = 2'($urandom_range(0, 3));
            a = $urandom;
            r = $urandom_range(0, 19);
            if (r < 14) ack = 1 + (r % 4);
            else if (r < 16) ack = 0;
            else if (r < 18) ack = 16;
            else ack = 17;
            issue(e, rw, sz, 1'($urandom_range(0, 1)), e & !rw, 1'($urandom_range(0, 1)),
                  a, $urandom, $urandom, ack);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
